// File: rtl/wb_axi_burst_data_channel.sv
// wb_axi_burst_data_channel: moves one AXI burst between the Wishbone data side and the AXI W or R channel through a beat FIFO
//
// Ports:
//   ACLK, ARESETN              clock, asynchronous active-low reset
//   burst_start, burst_len     burst request from the address FSM (beats = burst_len + 1)
//   busy, done, err            burst in progress, one-cycle completion pulse, sticky read error
//   wb_dat_i, wb_sel           Wishbone write beat and byte strobes (WRITE)
//   wb_dat_o                   Wishbone read beat (READ)
//   data_valid, data_ready     Wishbone beat handshake
//   axi_w*                     AXI W channel (WRITE)
//   axi_r*                     AXI R channel (READ)
module wb_axi_burst_data_channel #(
    parameter int    DATA_WIDTH = 32,
    parameter int    LEN_WIDTH  = 8,
    parameter int    FIFO_DEPTH = 4,
    parameter string CHANNEL    = "WRITE"
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    burst_start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + SW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam bit IS_WR = (CHANNEL == "WRITE");
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]         state;
    logic [LEN_WIDTH:0] len, in_cnt, out_cnt;
    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               rx_end, err_q;
    logic               active, full, empty, push, pop, fin, len_hit, resp_err;
    logic [EW-1:0]      head, push_dat;

    assign active   = state == S_ACTIVE;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign head     = mem[rd_ptr];
    assign len_hit  = in_cnt == len;
    // SLVERR and DECERR both have bit 1 set
    assign resp_err = axi_rresp >= 2'd2;

    assign busy       = state != S_IDLE;
    assign done       = state == S_DONE;
    assign err        = !IS_WR && err_q;
    assign axi_wvalid = IS_WR && active && !empty;
    assign axi_wlast  = axi_wvalid && out_cnt == len;
    // Head data is gated so idle outputs read as zero rather than stale FIFO contents
    assign axi_wdata  = axi_wvalid ? head[EW-1:SW] : '0;
    assign axi_wstrb  = axi_wvalid ? head[SW-1:0] : '0;
    assign axi_rready = !IS_WR && active && !full && !rx_end;
    assign data_ready = IS_WR ? (active && !full && in_cnt <= len) : (active && !empty);
    assign wb_dat_o   = (!IS_WR && data_ready) ? head[EW-1:SW] : '0;
    assign push       = IS_WR ? (data_valid && data_ready) : (axi_rvalid && axi_rready);
    assign pop        = IS_WR ? (axi_wvalid && axi_wready) : (data_valid && data_ready);
    assign push_dat   = IS_WR ? {wb_dat_i, wb_sel} : {axi_rdata, {SW{1'b0}}};
    assign fin        = IS_WR ? (pop && out_cnt == len) : (rx_end && empty);

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= S_IDLE;
            len     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_end  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && burst_start) begin
                state   <= S_ACTIVE;
                len     <= {1'b0, burst_len};
                in_cnt  <= '0;
                out_cnt <= '0;
                rx_end  <= 1'b0;
                err_q   <= 1'b0;
            end else if (active && fin) begin
                state <= S_DONE;
            end else if (state != S_ACTIVE) begin
                state <= S_IDLE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_cnt <= in_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_cnt <= out_cnt + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // An early rlast or a missing rlast on the final beat both flag a protocol error
            if (!IS_WR && push) begin
                err_q  <= err_q | resp_err | (axi_rlast ^ len_hit);
                rx_end <= rx_end | axi_rlast | len_hit;
            end
        end
    end
endmodule

// File: tb/tb_wb_axi_burst_data_channel.sv
// tb_wb_axi_burst_data_channel: checks WRITE and READ instances against a queue-based burst model
module tb_wb_axi_burst_data_channel;
    logic clk = 1'b0;
    logic ARESETN = 1'b0;
    always #5 clk = ~clk;

    logic        w_start = 0, w_busy, w_done, w_err, w_dv = 0, w_dr, w_wlast, w_wvalid, w_wready = 0, w_rready;
    logic [7:0]  w_len = 0;
    logic [31:0] w_dat = 0, w_dato, w_wdata;
    logic [3:0]  w_sel = 0, w_wstrb;
    logic        r_start = 0, r_busy, r_done, r_err, r_dv = 0, r_dr, r_wlast, r_wvalid, r_rready;
    logic        r_rlast = 0, r_rvalid = 0;
    logic [1:0]  r_rresp = 0;
    logic [7:0]  r_len = 0;
    logic [31:0] r_dato, r_wdata, r_rdata = 0;
    logic [3:0]  r_wstrb;

    wb_axi_burst_data_channel #(.CHANNEL("WRITE")) dut_w (
        .ACLK(clk), .ARESETN(ARESETN), .burst_start(w_start), .burst_len(w_len),
        .busy(w_busy), .done(w_done), .err(w_err), .wb_dat_i(w_dat), .wb_sel(w_sel),
        .wb_dat_o(w_dato), .data_valid(w_dv), .data_ready(w_dr), .axi_wdata(w_wdata),
        .axi_wstrb(w_wstrb), .axi_wlast(w_wlast), .axi_wvalid(w_wvalid), .axi_wready(w_wready),
        .axi_rdata(32'h0), .axi_rresp(2'b00), .axi_rlast(1'b0), .axi_rvalid(1'b0), .axi_rready(w_rready)
    );

    wb_axi_burst_data_channel #(.CHANNEL("READ")) dut_r (
        .ACLK(clk), .ARESETN(ARESETN), .burst_start(r_start), .burst_len(r_len),
        .busy(r_busy), .done(r_done), .err(r_err), .wb_dat_i(32'h0), .wb_sel(4'h0),
        .wb_dat_o(r_dato), .data_valid(r_dv), .data_ready(r_dr), .axi_wdata(r_wdata),
        .axi_wstrb(r_wstrb), .axi_wlast(r_wlast), .axi_wvalid(r_wvalid), .axi_wready(1'b0),
        .axi_rdata(r_rdata), .axi_rresp(r_rresp), .axi_rlast(r_rlast), .axi_rvalid(r_rvalid), .axi_rready(r_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Burst model: phase 0 idle, 1 active, 2 done; beats held in queues
    int          mw_ph = 0, mw_len = 0, mw_in = 0, mw_out = 0;
    logic [35:0] mw_q[$];
    int          mr_ph = 0, mr_len = 0, mr_in = 0;
    bit          mr_rx_end = 0, mr_err = 0;
    logic [31:0] mr_q[$];
    bit          ew_dr, ew_v, w_push, w_pop, er_rr, er_dr, r_fin;
    logic [35:0] ew_h;
    logic [31:0] er_d;

    always @(negedge clk) begin
        if (!ARESETN) begin
            mw_ph = 0; mw_len = 0; mw_in = 0; mw_out = 0; mw_q.delete();
            mr_ph = 0; mr_len = 0; mr_in = 0; mr_rx_end = 0; mr_err = 0; mr_q.delete();
            chk("reset_w_ctrl", {w_busy, w_done, w_err, w_dr, w_wvalid, w_wlast, w_rready, w_wstrb}, 0);
            chk("reset_w_data", {w_wdata, w_dato}, 0);
            chk("reset_r_ctrl", {r_busy, r_done, r_err, r_dr, r_wvalid, r_wlast, r_rready, r_wstrb}, 0);
            chk("reset_r_data", {r_wdata, r_dato}, 0);
        end else begin
            ew_dr = mw_ph == 1 && mw_q.size() < 4 && mw_in <= mw_len;
            ew_v  = mw_ph == 1 && mw_q.size() != 0;
            ew_h  = ew_v ? mw_q[0] : 36'h0;
            chk("w_busy", w_busy, mw_ph != 0);
            chk("w_done", w_done, mw_ph == 2);
            chk("w_data_ready", w_dr, ew_dr);
            chk("w_wvalid", w_wvalid, ew_v);
            chk("w_wdata_wstrb", {w_wdata, w_wstrb}, ew_h);
            chk("w_wlast", w_wlast, ew_v && mw_out == mw_len);
            chk("w_read_side_zero", {w_rready, w_err, w_dato}, 0);
            w_push = w_dv && ew_dr;
            w_pop  = ew_v && w_wready;
            if (mw_ph == 0) begin
                if (w_start) begin mw_ph = 1; mw_len = int'(w_len); mw_in = 0; mw_out = 0; end
            end else if (mw_ph == 1) begin
                if (w_pop) begin
                    void'(mw_q.pop_front());
                    if (mw_out == mw_len) mw_ph = 2;
                    mw_out++;
                end
                if (w_push) begin mw_q.push_back({w_dat, w_sel}); mw_in++; end
            end else mw_ph = 0;

            er_rr = mr_ph == 1 && mr_q.size() < 4 && !mr_rx_end;
            er_dr = mr_ph == 1 && mr_q.size() != 0;
            er_d  = er_dr ? mr_q[0] : 32'h0;
            chk("r_busy", r_busy, mr_ph != 0);
            chk("r_done", r_done, mr_ph == 2);
            chk("r_rready", r_rready, er_rr);
            chk("r_data_ready", r_dr, er_dr);
            chk("r_wb_dat_o", r_dato, er_d);
            chk("r_err", r_err, mr_err);
            chk("r_write_side_zero", {r_wvalid, r_wlast, r_wdata, r_wstrb}, 0);
            if (mr_ph == 0) begin
                if (r_start) begin mr_ph = 1; mr_len = int'(r_len); mr_in = 0; mr_rx_end = 0; mr_err = 0; end
            end else if (mr_ph == 1) begin
                r_fin = mr_rx_end && mr_q.size() == 0;
                if (r_dv && er_dr) void'(mr_q.pop_front());
                if (r_rvalid && er_rr) begin
                    if (r_rresp[1] || (r_rlast && mr_in != mr_len) || (!r_rlast && mr_in == mr_len)) mr_err = 1;
                    if (r_rlast || mr_in == mr_len) mr_rx_end = 1;
                    mr_q.push_back(r_rdata);
                    mr_in++;
                end
                if (r_fin) mr_ph = 2;
            end else mr_ph = 0;
        end
    end

    task automatic run_w(input int len, input int stall, input logic [31:0] base, input logic [31:0] step, input int poke);
        int i = 0, first = -1, last_hs = -1, done_cyc = -1, lasts = 0, stalled_push = 0;
        bit acc;
        logic [31:0] got[$];
        @(posedge clk); #1 w_start = 1; w_len = 8'(len);
        @(posedge clk); #1 w_start = 0; w_dv = 1; w_dat = base; w_sel = 4'hF;
        for (int c = 0; c < 300 && done_cyc < 0; c++) begin
            w_wready = c >= stall;
            w_start  = c == poke;
            w_len    = (c == poke) ? 8'd5 : 8'(len);
            @(negedge clk);
            acc = w_dv && w_dr;
            if (acc && !w_wready) stalled_push++;
            if (w_wvalid && w_wready) begin
                got.push_back(w_wdata);
                if (first < 0) first = c;
                last_hs = c;
                if (w_wlast) lasts++;
            end
            if (w_done) done_cyc = c;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                w_dat = base + 32'(i) * step;
                if (i > len) w_dv = 0;
            end
        end
        w_dv = 0; w_start = 0; w_wready = 0;
        chk("w_done_seen", done_cyc >= 0, 1);
        chk("w_done_latency", done_cyc - last_hs, 1);
        chk("w_beat_count", got.size(), len + 1);
        for (int k = 0; k < got.size(); k++) chk("w_beat_order", got[k], base + 32'(k) * step);
        chk("w_wlast_count", lasts, 1);
        if (stall == 0) chk("w_back_to_back", last_hs - first, len);
        else chk("w_pushes_while_stalled", stalled_push, 4);
    endtask

    task automatic run_r(input int len, input int nbeats, input int err_beat, input int last_beat,
                         input int pop_delay, input bit every_other, input logic [31:0] base, input bit exp_err);
        int j = 0, done_cyc = -1;
        bit acc, err_at_done = 0;
        logic [31:0] got[$];
        @(posedge clk); #1 r_start = 1; r_len = 8'(len);
        @(posedge clk); #1 r_start = 0; r_rvalid = 1; r_rdata = base;
        r_rresp = (err_beat == 0) ? 2'b10 : 2'b00; r_rlast = last_beat == 0;
        for (int c = 0; c < 300 && done_cyc < 0; c++) begin
            r_dv = c >= pop_delay && (!every_other || c % 2 == 0);
            @(negedge clk);
            acc = r_rvalid && r_rready;
            if (r_dv && r_dr) got.push_back(r_dato);
            if (r_done) begin done_cyc = c; err_at_done = r_err; end
            @(posedge clk); #1;
            if (acc) begin
                j++;
                r_rvalid = j < nbeats;
                r_rdata = base + 32'(j) * 32'h10;
                r_rresp = (j == err_beat) ? 2'b10 : 2'b00;
                r_rlast = j == last_beat;
            end
        end
        r_dv = 0; r_rvalid = 0; r_rlast = 0; r_rresp = 0;
        chk("r_done_seen", done_cyc >= 0, 1);
        chk("r_beat_count", got.size(), nbeats);
        for (int k = 0; k < got.size(); k++) chk("r_beat_order", got[k], base + 32'(k) * 32'h10);
        chk("r_err_at_done", err_at_done, exp_err);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1 w_start = 1; w_len = 8'd7; r_start = 1; r_len = 8'd7;
        @(posedge clk); #1 w_start = 0; r_start = 0; w_dv = 1; w_dat = 32'hA0; w_sel = 4'hF; w_wready = 0;
        r_rvalid = 1; r_rdata = 32'hB0; r_dv = 0;
        @(posedge clk); #1 w_dat = 32'hA1; r_rdata = 32'hB1;
        @(posedge clk); #1 w_dv = 0; r_rvalid = 0;
        @(negedge clk);
        chk("pre_reset_w_head", {w_wvalid, w_wdata}, {1'b1, 32'hA0});
        chk("pre_reset_r_head", {r_dr, r_dato}, {1'b1, 32'hB0});
        @(posedge clk); #1 ARESETN = 0;
        @(negedge clk);
        chk("in_reset_outputs", {w_busy, w_wvalid, r_busy, r_dr, r_rready}, 0);
        repeat (2) @(posedge clk);
        #1 ARESETN = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_done_after_reset", {w_done, r_done, w_busy, r_busy}, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 ARESETN = 1;
        run_w(3, 0, 32'h11, 32'h11, -1);
        run_w(7, 10, 32'h100, 32'h1, -1);
        run_w(0, 0, 32'hCAFE0000, 32'h0, 1);
        run_r(3, 4, -1, 3, 0, 1, 32'h1000, 0);
        run_r(5, 6, -1, 5, 8, 0, 32'h2000, 0);
        run_r(3, 4, 1, 3, 0, 0, 32'h3000, 1);
        run_r(3, 2, -1, 1, 0, 0, 32'h4000, 1);
        reset_mid();
        run_w(3, 0, 32'h55, 32'h1, -1);
        run_r(3, 4, -1, 3, 0, 0, 32'h5000, 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_axi_burst_data_channel.md
Name: wb_axi_burst_data_channel

Overview:
Parametrised successor to the single-beat WB-to-AXI data channel converter. It moves a whole AXI burst (1 to 2^LEN_WIDTH beats) between the Wishbone data side and the AXI W or R channel. An internal FIFO decouples the two sides. It sits between the bridge address/control FSM, which issues burst_start/burst_len after the AW/AR handshake, and the AXI interconnect port.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8, minimum 8)
LEN_WIDTH, 8, width of burst_len (AXI4 AxLEN encoding, beats = burst_len+1)
FIFO_DEPTH, 4, beat buffer entries (power of 2, minimum 2)
CHANNEL, "WRITE", "WRITE" selects W-channel datapath; "READ" selects R-channel datapath

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
burst_start  in  1  one-cycle request to begin a burst (honoured only in IDLE)
burst_len  in  LEN_WIDTH  beats minus one, sampled with burst_start
busy  out  1  burst in progress
done  out  1  one-cycle pulse when burst fully completed
err  out  1  sticky error for current burst (READ only), valid with done
wb_dat_i  in  DATA_WIDTH  write beat data (WRITE)
wb_sel  in  DATA_WIDTH/8  write byte strobes (WRITE)
wb_dat_o  out  DATA_WIDTH  read beat data (READ)
data_valid  in  1  WB side offers a beat (WRITE) / wants a beat (READ)
data_ready  out  1  beat accepted (WRITE) / beat available on wb_dat_o (READ)
axi_wdata  out  DATA_WIDTH  AXI W data
axi_wstrb  out  DATA_WIDTH/8  AXI W strobes
axi_wlast  out  1  AXI W last beat
axi_wvalid  out  1  AXI W valid
axi_wready  in  1  AXI W ready
axi_rdata  in  DATA_WIDTH  AXI R data
axi_rresp  in  2  AXI R response
axi_rlast  in  1  AXI R last
axi_rvalid  in  1  AXI R valid
axi_rready  out  1  AXI R ready

Behaviour:
- Reset: FSM=IDLE, FIFO empty, all counters 0; busy, done, err, data_ready, axi_wvalid, axi_wlast, axi_rready = 0; axi_wdata, axi_wstrb, wb_dat_o = 0. Reset mid-burst discards FIFO contents and counters with no completion pulse.
- FSM: IDLE -> ACTIVE on burst_start (latch burst_len, clear in_cnt/out_cnt/err). ACTIVE -> DONE when the final beat leaves the block. DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE. busy=1 in ACTIVE and DONE.
- burst_start outside IDLE is ignored.
- Counters are LEN_WIDTH+1 bits, so burst_len = all-ones (256 beats at default) never wraps.
- FIFO: push and pop in the same cycle are allowed; count is unchanged. When full, push is blocked even if a pop occurs in that cycle; there is no combinational bypass. Pop on empty never occurs.
- WRITE mode:
  - data_ready = ACTIVE & !full & (in_cnt <= len), combinational.
  - Push {wb_dat_i, wb_sel} on data_valid & data_ready; in_cnt++.
  - axi_wvalid = ACTIVE & !empty. axi_wdata/axi_wstrb = FIFO head. axi_wlast = axi_wvalid & (out_cnt == len).
  - Pop on axi_wvalid & axi_wready; out_cnt++.
  - Pop with out_cnt == len -> DONE.
  - Once asserted, axi_wvalid and head data hold until wready (AXI stability).
  - Minimum latency: a beat pushed at cycle N is presented on W at N+1.
  - R outputs: axi_rready=0, wb_dat_o=0, err=0.
- READ mode:
  - axi_rready = ACTIVE & !full & !rx_end, where rx_end is set after the last beat is accepted.
  - Push rdata on axi_rvalid & axi_rready; in_cnt++.
  - err |= axi_rresp[1] on each accepted beat.
  - err is also set if axi_rlast is seen with in_cnt != len, or in_cnt == len without rlast.
  - rx_end sets on an accepted beat with rlast or in_cnt == len, whichever comes first. An early rlast truncates the burst.
  - data_ready = ACTIVE & !empty. wb_dat_o = FIFO head. Pop on data_valid & data_ready.
  - DONE when rx_end & FIFO empty (after the final pop).
  - err holds until the next burst_start.
  - W outputs are tied to 0.
- With FIFO_DEPTH >= 2 and both sides always ready, throughput is 1 beat/cycle.

Test Plan:
- WRITE, burst_len=3, data_valid and wready held high, data 0x11..0x44, wb_sel=0xF: 4 W beats with consecutive valid, wlast only on 0x44, done 1 cycle after the last handshake.
- WRITE, burst_len=7, wready low for 10 cycles: data_ready drops after 4 pushes (FIFO full). On release, 8 beats arrive in order with wvalid/wdata stable while stalled.
- WRITE, burst_len=0: single beat with wlast=1. A burst_start during ACTIVE is ignored and busy never drops mid-burst.
- READ, burst_len=3, rresp=OKAY, rlast on beat 4, WB pops every other cycle: wb_dat_o matches the AXI order, rready deasserts on full, done with err=0.
- READ, burst_len=3, SLVERR on beat 2, then a separate burst with rlast on beat 2: both complete with err=1. The second completes after 2 beats.
- Assert ARESETN low mid-burst (READ and WRITE) with 2 beats buffered: all outputs go to reset values at once, no done pulse, and a new burst then runs cleanly.
